soc_run_monitor: RTL and testbench
==================================

// Module: soc_run_monitor
// PURPOSE
//  Synthesizable run monitor that sits beside the CPU subsystem in the SoC. It snoops the retire ports,
//  the writeback data ports and the BIU AXI write channel. It reports PASS, FAIL or HANG through
//  sticky status outputs and keeps cycle and instret counters. Console bytes written to CON_ADDR are
//  buffered in a FIFO with a valid/ready drain port. It replaces per-bench $display monitors, and
//  generalises them to N retire ports, N writeback ports and any AXI data width.
// PARAMETERS
//  DATA_W      128              AXI wdata width; multiple of 32, from 32 to 512
//  ADDR_W      40               AXI address width
//  NUM_RET     1                retire ports (instructions retired per cycle)
//  NUM_WB      2                writeback data ports checked for magic values
//  WB_W        64               writeback data width
//  WDOG_CYC    50000            watchdog window in cycles (>=2)
//  CON_ADDR    40'h0090000000   console byte address
//  PASS_VAL    64'h444333222    writeback value that signals PASS (zero-extended/truncated to WB_W)
//  FAIL_VAL    64'h2382348720   writeback value that signals FAIL
//  FIFO_DEPTH  16               console FIFO entries; power of 2, >=2
// PORTS
//  clk           in   1               clock
//  rst_b         in   1               asynchronous active-low reset
//  mon_en        in   1               1 = watchdog armed; 0 = window counter held at 0 (debug halt)
//  retire        in   NUM_RET         per-port retire pulse
//  wb_vld        in   NUM_WB          per-port writeback valid
//  wb_data       in   NUM_WB*WB_W     writeback data; port k is bits [k*WB_W +: WB_W]
//  awvalid/awready in 1               AXI AW handshake (snoop only)
//  awaddr        in   ADDR_W          AXI AW address
//  awlen         in   8               AXI AW burst length
//  wvalid/wready in   1               AXI W handshake (snoop only)
//  wdata         in   DATA_W          AXI write data
//  wstrb         in   DATA_W/8        AXI write strobes
//  status        out  2               0 RUN, 1 PASS, 2 FAIL, 3 HANG
//  done          out  1               status != RUN
//  cycles        out  64              cycles since reset
//  instret       out  64              retired instructions since reset
//  con_vld       out  1               console FIFO not empty
//  con_data      out  8               console FIFO head byte
//  con_rdy       in   1               pop when con_vld & con_rdy
//  con_ovf       out  1               sticky: a console byte was dropped because the FIFO was full
// BEHAVIOUR
//  Reset: status=RUN, done=0, cycles=0, instret=0, con_vld=0, con_data=0, con_ovf=0; FIFO empty, window cleared.
//  FSM RUN->PASS|FAIL|HANG. All three are terminal until rst_b asserts.
//  RUN exits when, in the same cycle, any port k has wb_vld[k] & wb_data_k==PASS_VAL -> PASS.
//    Otherwise, if any valid port matches FAIL_VAL -> FAIL. Otherwise a watchdog expiry -> HANG.
//    Priority is PASS>FAIL>HANG. status and done update on the edge after the match (1-cycle latency).
//  Counters run in RUN only and freeze once the FSM leaves RUN. cycles +1 per cycle.
//    instret += popcount(retire). Both wrap modulo 2^64.
//  Watchdog: a window counter counts 0..WDOG_CYC-1 while mon_en=1 and status=RUN, and wraps to 0.
//    A per-window retire flag sets on any retire bit. Expiry happens on the cycle where the counter
//    equals WDOG_CYC-1 and neither the flag nor the current-cycle retire is set. On wrap, the flag clears.
//    When mon_en=0, the counter and flag are held at 0, so a fresh full window starts when mon_en rises.
//  Console snoop, AW side: an AW handshake with awlen==0 and awaddr[ADDR_W-1:LSB]==CON_ADDR[ADDR_W-1:LSB]
//    (LSB=log2(DATA_W/8)) sets pending. Any other AW handshake clears pending.
//  Console snoop, W side: the SoC BIU never issues W ahead of its AW. The W handshake in the same cycle as
//    the matching AW, or the first one after it, consumes pending. If wstrb == 4'hF<<(4*n) for some
//    lane n, byte wdata[32*n +: 8] is pushed. Any other strobe pattern is ignored, and pending still clears.
//    W beats with no pending are ignored.
//  Console snoop continues in every status so trailing prints still drain.
//  FIFO: one push and one pop per cycle maximum. Push and pop in the same cycle when full is allowed;
//    the count is unchanged. Push when full (no pop): byte dropped, con_ovf set. Pop when empty: no-op.
//    Pointers wrap modulo FIFO_DEPTH. con_data is valid whenever con_vld=1; the head is registered.
//  Reset mid-operation clears everything above asynchronously, including a pending console write
//    and the FIFO contents.
// TESTING
//  1. Reset; retire=1 for 10 cycles, then wb_vld[1]=1 with wb_data_1=64'h444333222 -> status=1 and done=1
//     on the next edge; instret=10; cycles frozen from then on.
//  2. Same cycle: wb port0=FAIL_VAL and port1=PASS_VAL, both valid -> status=1 (PASS priority).
//     Repeat with port1 invalid -> status=2.
//  3. WDOG_CYC=8 with no retire -> status=3 after 8 cycles. A retire in cycle 7 of the window prevents HANG.
//     mon_en=0 for 20 cycles -> no HANG.
//  4. AW 0x90000000 awlen=0, W wstrb=16'h0F00 wdata[71:64]=8'h41 -> 'A' at con_data with con_vld=1.
//     wstrb=16'h00FF -> nothing pushed. Same AW with awlen=1 -> nothing pushed.
//  5. 17 console writes with FIFO_DEPTH=16 and con_rdy=0 -> 16 bytes held, con_ovf=1. Then con_rdy=1
//     -> bytes drain in order. Push and pop together while full -> count stays 16 and order is preserved.
//  6. Assert rst_b low while pending=1 and the FIFO holds 5 bytes -> all outputs return to reset values
//     immediately. A W beat after release pushes nothing.

Source files
------------

// File: rtl/soc_run_monitor.sv
// ---------------------------------------------------------------------------
// soc_run_monitor
//
// Run monitor placed beside the CPU subsystem. It snoops the retire ports,
// the writeback data ports and the BIU AXI write channel, and reports the
// run outcome through sticky status outputs. It also keeps cycle and
// instret counters and buffers console bytes in a small drain FIFO.
//
// Ports
//   clk, rst_b          clock, asynchronous active-low reset
//   mon_en              1 arms the watchdog; 0 holds the window at 0
//   retire[NUM_RET]     per-port retire pulses
//   wb_vld[NUM_WB]      per-port writeback valid
//   wb_data             NUM_WB packed writeback words, port k at [k*WB_W +: WB_W]
//   awvalid/awready     AXI AW handshake (snoop only)
//   awaddr, awlen       AXI AW address and burst length
//   wvalid/wready       AXI W handshake (snoop only)
//   wdata, wstrb        AXI write data and strobes
//   status              0 RUN, 1 PASS, 2 FAIL, 3 HANG (sticky)
//   done                status != RUN
//   cycles, instret     64-bit counters, frozen once status leaves RUN
//   con_vld, con_data   console FIFO head (valid/ready drain)
//   con_rdy             pops the head when con_vld is high
//   con_ovf             sticky: a console byte was dropped on a full FIFO
// ---------------------------------------------------------------------------
module soc_run_monitor #(
    parameter int unsigned       DATA_W     = 128,
    parameter int unsigned       ADDR_W     = 40,
    parameter int unsigned       NUM_RET    = 1,
    parameter int unsigned       NUM_WB     = 2,
    parameter int unsigned       WB_W       = 64,
    parameter int unsigned       WDOG_CYC   = 50000,
    parameter logic [ADDR_W-1:0] CON_ADDR   = 40'h0090000000,
    parameter logic [63:0]       PASS_VAL   = 64'h444333222,
    parameter logic [63:0]       FAIL_VAL   = 64'h2382348720,
    parameter int unsigned       FIFO_DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_b,
    input  logic                   mon_en,
    input  logic [NUM_RET-1:0]     retire,
    input  logic [NUM_WB-1:0]      wb_vld,
    input  logic [NUM_WB*WB_W-1:0] wb_data,
    input  logic                   awvalid,
    input  logic                   awready,
    input  logic [ADDR_W-1:0]      awaddr,
    input  logic [7:0]             awlen,
    input  logic                   wvalid,
    input  logic                   wready,
    input  logic [DATA_W-1:0]      wdata,
    input  logic [DATA_W/8-1:0]    wstrb,
    output logic [1:0]             status,
    output logic                   done,
    output logic [63:0]            cycles,
    output logic [63:0]            instret,
    output logic                   con_vld,
    output logic [7:0]             con_data,
    input  logic                   con_rdy,
    output logic                   con_ovf
);

    // -----------------------------------------------------------------------
    // Derived constants
    // -----------------------------------------------------------------------
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned LSB    = $clog2(STRB_W);
    localparam int unsigned LANES  = DATA_W / 32;
    localparam int unsigned WIN_W  = $clog2(WDOG_CYC);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned RET_CW = $clog2(NUM_RET + 1);

    localparam logic [WIN_W-1:0] WIN_LAST   = WIN_W'(WDOG_CYC - 1);
    localparam logic [CNT_W-1:0] FIFO_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [WB_W-1:0]  PASS_MAGIC = WB_W'(PASS_VAL);
    localparam logic [WB_W-1:0]  FAIL_MAGIC = WB_W'(FAIL_VAL);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PASS = 2'd1,
        ST_FAIL = 2'd2,
        ST_HANG = 2'd3
    } state_t;

    // -----------------------------------------------------------------------
    // Signals
    // -----------------------------------------------------------------------
    state_t               state_q;
    state_t               state_d;

    logic                 pass_hit;
    logic                 fail_hit;
    logic                 any_ret;
    logic [RET_CW-1:0]    ret_cnt;

    logic [WIN_W-1:0]     win_cnt_q;
    logic                 win_flag_q;
    logic                 wdog_armed;
    logic                 win_at_last;
    logic                 wdog_expire;

    logic [63:0]          cycles_q;
    logic [63:0]          instret_q;

    logic                 aw_hs;
    logic                 w_hs;
    logic                 aw_match;
    logic                 pend_q;
    logic                 pend_eff;
    logic                 consume;
    logic                 lane_hit;
    logic [7:0]           lane_byte;
    logic                 push;

    logic [7:0]           mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [CNT_W-1:0]     count_q;
    logic                 ovf_q;
    logic                 fifo_full;
    logic                 pop;
    logic                 wr_en;

    logic                 unused_bits;

    // Only the lane bytes and the line-address bits are inspected.
    assign unused_bits = ^{wdata, awaddr[LSB-1:0]};

    // -----------------------------------------------------------------------
    // Writeback magic-value detection and retire popcount
    // -----------------------------------------------------------------------
    always_comb begin
        pass_hit = 1'b0;
        fail_hit = 1'b0;
        for (int unsigned k = 0; k < NUM_WB; k++) begin
            if (wb_vld[k]) begin
                if (wb_data[k*WB_W +: WB_W] == PASS_MAGIC) pass_hit = 1'b1;
                if (wb_data[k*WB_W +: WB_W] == FAIL_MAGIC) fail_hit = 1'b1;
            end
        end
    end

    always_comb begin
        ret_cnt = '0;
        for (int unsigned i = 0; i < NUM_RET; i++) begin
            ret_cnt = ret_cnt + RET_CW'(retire[i]);
        end
    end

    assign any_ret = |retire;

    // -----------------------------------------------------------------------
    // Watchdog window
    // -----------------------------------------------------------------------
    assign wdog_armed  = mon_en && (state_q == ST_RUN);
    assign win_at_last = (win_cnt_q == WIN_LAST);
    // A retire in the last cycle of the window still counts for that window.
    assign wdog_expire = wdog_armed && win_at_last && !win_flag_q && !any_ret;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            win_cnt_q  <= '0;
            win_flag_q <= 1'b0;
        end else if (!wdog_armed || win_at_last) begin
            win_cnt_q  <= '0;
            win_flag_q <= 1'b0;
        end else begin
            win_cnt_q  <= win_cnt_q + 1'b1;
            win_flag_q <= win_flag_q | any_ret;
        end
    end

    // -----------------------------------------------------------------------
    // Run-state FSM (PASS > FAIL > HANG; all exits are terminal)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == ST_RUN) begin
            if (pass_hit) begin
                state_d = ST_PASS;
            end else if (fail_hit) begin
                state_d = ST_FAIL;
            end else if (wdog_expire) begin
                state_d = ST_HANG;
            end
        end
    end

    assign status = state_q;
    assign done   = (state_q != ST_RUN);

    // -----------------------------------------------------------------------
    // Cycle and instret counters
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cycles_q  <= '0;
            instret_q <= '0;
        end else if (state_q == ST_RUN) begin
            cycles_q  <= cycles_q + 64'd1;
            instret_q <= instret_q + 64'(ret_cnt);
        end
    end

    assign cycles  = cycles_q;
    assign instret = instret_q;

    // -----------------------------------------------------------------------
    // Console snoop
    // -----------------------------------------------------------------------
    assign aw_hs    = awvalid && awready;
    assign w_hs     = wvalid && wready;
    assign aw_match = (awlen == 8'd0) &&
                      (awaddr[ADDR_W-1:LSB] == CON_ADDR[ADDR_W-1:LSB]);

    // An AW in this cycle decides ownership of a W in the same cycle.
    assign pend_eff = aw_hs ? aw_match : pend_q;
    assign consume  = w_hs && pend_eff;

    always_comb begin
        lane_hit  = 1'b0;
        lane_byte = '0;
        for (int unsigned n = 0; n < LANES; n++) begin
            if (wstrb == (STRB_W'(4'hF) << (4 * n))) begin
                lane_hit  = 1'b1;
                lane_byte = wdata[32*n +: 8];
            end
        end
    end

    assign push = consume && lane_hit;

    // Any W handshake either consumes the pending write or finds none, so
    // pending survives only when no W beat is seen.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= pend_eff && !w_hs;
        end
    end

    // -----------------------------------------------------------------------
    // Console FIFO
    // -----------------------------------------------------------------------
    assign fifo_full = (count_q == FIFO_FULL);
    assign pop       = con_vld && con_rdy;
    // When full, a simultaneous pop frees the head slot that wr_ptr points at.
    assign wr_en     = push && (!fifo_full || pop);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_ptr_q] <= lane_byte;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({wr_en, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (push && !wr_en) ovf_q <= 1'b1;
        end
    end

    assign con_vld  = (count_q != '0);
    assign con_data = mem[rd_ptr_q];
    assign con_ovf  = ovf_q;

endmodule

// File: tb/tb_soc_run_monitor.sv
module tb_soc_run_monitor;

    localparam int          WDOG   = 8;
    localparam int          DEPTH  = 16;
    localparam logic [63:0] PASS_V = 64'h444333222;
    localparam logic [63:0] FAIL_V = 64'h2382348720;
    localparam logic [39:0] CON_A  = 40'h0090000000;

    logic          clk;
    logic          rst_b;
    logic          mon_en;
    logic [1:0]    retire;
    logic [1:0]    wb_vld;
    logic [127:0]  wb_data;
    logic          awvalid, awready;
    logic [39:0]   awaddr;
    logic [7:0]    awlen;
    logic          wvalid, wready;
    logic [127:0]  wdata;
    logic [15:0]   wstrb;
    logic [1:0]    status;
    logic          done;
    logic [63:0]   cycles, instret;
    logic          con_vld;
    logic [7:0]    con_data;
    logic          con_rdy;
    logic          con_ovf;

    soc_run_monitor #(
        .DATA_W    (128),
        .ADDR_W    (40),
        .NUM_RET   (2),
        .NUM_WB    (2),
        .WB_W      (64),
        .WDOG_CYC  (WDOG),
        .CON_ADDR  (CON_A),
        .PASS_VAL  (PASS_V),
        .FAIL_VAL  (FAIL_V),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk     (clk),
        .rst_b   (rst_b),
        .mon_en  (mon_en),
        .retire  (retire),
        .wb_vld  (wb_vld),
        .wb_data (wb_data),
        .awvalid (awvalid),
        .awready (awready),
        .awaddr  (awaddr),
        .awlen   (awlen),
        .wvalid  (wvalid),
        .wready  (wready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .status  (status),
        .done    (done),
        .cycles  (cycles),
        .instret (instret),
        .con_vld (con_vld),
        .con_data(con_data),
        .con_rdy (con_rdy),
        .con_ovf (con_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [1:0]       m_status;
    longint unsigned  m_cycles;
    longint unsigned  m_instret;
    int               m_idle_pos;   // cycles elapsed in the current armed window
    bit               m_seen;       // a retire was observed in this window
    bit               m_pend;
    bit               m_ovf;
    logic [7:0]       q[$];

    task automatic model_reset();
        m_status   = 2'd0;
        m_cycles   = 0;
        m_instret  = 0;
        m_idle_pos = 0;
        m_seen     = 0;
        m_pend     = 0;
        m_ovf      = 0;
        q.delete();
    endtask

    task automatic idle_inputs();
        mon_en  = 1'b1;
        retire  = '0;
        wb_vld  = '0;
        wb_data = '0;
        awvalid = 0; awready = 0; awaddr = '0; awlen = '0;
        wvalid  = 0; wready  = 0; wdata  = '0; wstrb = '0;
        con_rdy = 0;
    endtask

    // Advance one clock: update the model from the inputs presented this
    // cycle, then wait for the edge and settle.
    task automatic tick();
        bit          pass_h, fail_h, expire, aw_hs, w_hs, match, owned, have_byte;
        logic [7:0]  pb;
        logic [15:0] lane_strb;
        logic [1:0]  nxt;
        pass_h = 0; fail_h = 0; expire = 0; have_byte = 0; pb = '0;
        for (int k = 0; k < 2; k++) begin
            if (wb_vld[k] && wb_data[k*64 +: 64] == PASS_V) pass_h = 1;
            if (wb_vld[k] && wb_data[k*64 +: 64] == FAIL_V) fail_h = 1;
        end
        nxt = m_status;
        if (m_status == 2'd0) begin
            if (mon_en) begin
                if (m_idle_pos == WDOG - 1) begin
                    expire     = !m_seen && (retire == 0);
                    m_idle_pos = 0;
                    m_seen     = 0;
                end else begin
                    m_idle_pos++;
                    if (retire != 0) m_seen = 1;
                end
            end else begin
                m_idle_pos = 0;
                m_seen     = 0;
            end
            if (pass_h)      nxt = 2'd1;
            else if (fail_h) nxt = 2'd2;
            else if (expire) nxt = 2'd3;
            m_cycles  += 1;
            m_instret += $countones(retire);
        end
        aw_hs = awvalid && awready;
        w_hs  = wvalid && wready;
        match = (awlen == 0) && ((awaddr >> 4) == (CON_A >> 4));
        owned = aw_hs ? match : m_pend;
        if (w_hs && owned) begin
            for (int n = 0; n < 4; n++) begin
                lane_strb = 16'h000F << (4 * n);
                if (wstrb == lane_strb) begin
                    have_byte = 1;
                    pb = 8'(wdata >> (32 * n));
                end
            end
        end
        m_pend = owned && !w_hs;
        if (con_rdy && q.size() > 0) void'(q.pop_front());
        if (have_byte) begin
            if (q.size() < DEPTH) q.push_back(pb);
            else m_ovf = 1;
        end
        m_status = nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_b = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_b = 1'b1;
    endtask

    task automatic aw_beat(input logic [39:0] a, input logic [7:0] len);
        awvalid = 1; awready = 1; awaddr = a; awlen = len;
        tick();
        awvalid = 0; awready = 0;
    endtask

    task automatic w_beat(input logic [127:0] d, input logic [15:0] s);
        wvalid = 1; wready = 1; wdata = d; wstrb = s;
        tick();
        wvalid = 0; wready = 0;
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        idle_inputs();
        rst_b = 1'b0;
        model_reset();
        #3;
        tests++; if (status !== 2'd0)   begin fails++; $display("FAIL rst_status got=%0d exp=0", status); end
        tests++; if (done !== 1'b0)     begin fails++; $display("FAIL rst_done got=%0d exp=0", done); end
        tests++; if (cycles !== 64'd0)  begin fails++; $display("FAIL rst_cycles got=%0d exp=0", cycles); end
        tests++; if (instret !== 64'd0) begin fails++; $display("FAIL rst_instret got=%0d exp=0", instret); end
        tests++; if (con_vld !== 1'b0)  begin fails++; $display("FAIL rst_con_vld got=%0d exp=0", con_vld); end
        tests++; if (con_data !== 8'h0) begin fails++; $display("FAIL rst_con_data got=%0h exp=0", con_data); end
        tests++; if (con_ovf !== 1'b0)  begin fails++; $display("FAIL rst_con_ovf got=%0d exp=0", con_ovf); end
        do_reset();
        retire = 2'b11;
        tick();
        retire = 2'b00;
        tests++; if (cycles !== 64'd1)  begin fails++; $display("FAIL first_cycle got=%0d exp=1", cycles); end
        tests++; if (instret !== 64'd2) begin fails++; $display("FAIL first_instret got=%0d exp=2", instret); end
    endtask

    task automatic test_pass();
        do_reset();
        retire = 2'b01;
        repeat (10) tick();
        retire = 2'b00;
        tests++; if (status !== 2'd0) begin fails++; $display("FAIL pre_pass_status got=%0d exp=0", status); end
        wb_vld  = 2'b10;
        wb_data = {PASS_V, 64'h0};
        tick();
        wb_vld  = 2'b00;
        tests++; if (status !== 2'd1)    begin fails++; $display("FAIL pass_status got=%0d exp=1", status); end
        tests++; if (done !== 1'b1)      begin fails++; $display("FAIL pass_done got=%0d exp=1", done); end
        tests++; if (instret !== 64'd10) begin fails++; $display("FAIL pass_instret got=%0d exp=10", instret); end
        tests++; if (cycles !== 64'd11)  begin fails++; $display("FAIL pass_cycles got=%0d exp=11", cycles); end
        retire  = 2'b11;
        wb_vld  = 2'b01;
        wb_data = {64'h0, FAIL_V};
        repeat (5) tick();
        retire  = 2'b00;
        wb_vld  = 2'b00;
        tests++; if (cycles !== 64'd11)  begin fails++; $display("FAIL frozen_cycles got=%0d exp=11", cycles); end
        tests++; if (instret !== 64'd10) begin fails++; $display("FAIL frozen_instret got=%0d exp=10", instret); end
        tests++; if (status !== 2'd1)    begin fails++; $display("FAIL sticky_pass got=%0d exp=1", status); end
    endtask

    task automatic test_priority();
        do_reset();
        wb_vld  = 2'b11;
        wb_data = {PASS_V, FAIL_V};
        tick();
        wb_vld  = 2'b00;
        tests++; if (status !== 2'd1) begin fails++; $display("FAIL prio_pass got=%0d exp=1", status); end
        do_reset();
        wb_vld  = 2'b01;
        wb_data = {PASS_V, FAIL_V};
        tick();
        wb_vld  = 2'b00;
        tests++; if (status !== 2'd2) begin fails++; $display("FAIL prio_fail got=%0d exp=2", status); end
        tests++; if (done !== 1'b1)   begin fails++; $display("FAIL prio_fail_done got=%0d exp=1", done); end
        do_reset();
        wb_vld  = 2'b00;
        wb_data = {PASS_V, FAIL_V};
        tick();
        tests++; if (status !== 2'd0) begin fails++; $display("FAIL invalid_wb got=%0d exp=0", status); end
    endtask

    task automatic test_watchdog();
        do_reset();
        repeat (7) tick();
        tests++; if (status !== 2'd0) begin fails++; $display("FAIL wdog_early got=%0d exp=0", status); end
        tick();
        tests++; if (status !== 2'd3) begin fails++; $display("FAIL wdog_hang got=%0d exp=3", status); end
        tests++; if (cycles !== 64'd8) begin fails++; $display("FAIL wdog_cycles got=%0d exp=8", cycles); end
        do_reset();
        repeat (7) tick();
        retire = 2'b10;
        tick();
        retire = 2'b00;
        tests++; if (status !== 2'd0) begin fails++; $display("FAIL wdog_last_retire got=%0d exp=0", status); end
        repeat (7) tick();
        tests++; if (status !== 2'd0) begin fails++; $display("FAIL wdog_win2_early got=%0d exp=0", status); end
        tick();
        tests++; if (status !== 2'd3) begin fails++; $display("FAIL wdog_win2_hang got=%0d exp=3", status); end
        do_reset();
        retire = 2'b01;
        tick();
        retire = 2'b00;
        repeat (7) tick();
        tests++; if (status !== 2'd0) begin fails++; $display("FAIL wdog_first_retire got=%0d exp=0", status); end
        do_reset();
        mon_en = 1'b0;
        repeat (20) tick();
        tests++; if (status !== 2'd0) begin fails++; $display("FAIL wdog_disabled got=%0d exp=0", status); end
        mon_en = 1'b1;
        repeat (7) tick();
        tests++; if (status !== 2'd0) begin fails++; $display("FAIL wdog_rearm_early got=%0d exp=0", status); end
        tick();
        tests++; if (status !== 2'd3) begin fails++; $display("FAIL wdog_rearm_hang got=%0d exp=3", status); end
    endtask

    task automatic test_console();
        logic [127:0] d;
        do_reset();
        mon_en = 1'b0;
        d = '0;
        d[71:64] = 8'h41;
        aw_beat(40'h90000000, 8'd0);
        w_beat(d, 16'h0F00);
        tests++; if (con_vld !== 1'b1)   begin fails++; $display("FAIL con_a_vld got=%0d exp=1", con_vld); end
        tests++; if (con_data !== 8'h41) begin fails++; $display("FAIL con_a_data got=%0h exp=41", con_data); end
        con_rdy = 1'b1;
        tick();
        con_rdy = 1'b0;
        tests++; if (con_vld !== 1'b0) begin fails++; $display("FAIL con_a_drain got=%0d exp=0", con_vld); end
        aw_beat(40'h90000000, 8'd0);
        w_beat(d, 16'h00FF);
        tests++; if (con_vld !== 1'b0) begin fails++; $display("FAIL con_bad_strb got=%0d exp=0", con_vld); end
        aw_beat(40'h90000000, 8'd1);
        w_beat(d, 16'h0F00);
        tests++; if (con_vld !== 1'b0) begin fails++; $display("FAIL con_burst got=%0d exp=0", con_vld); end
        aw_beat(40'h90000010, 8'd0);
        w_beat(d, 16'h0F00);
        tests++; if (con_vld !== 1'b0) begin fails++; $display("FAIL con_other_line got=%0d exp=0", con_vld); end
        // AW and W together, address inside the console line
        d = '0;
        d[7:0] = 8'h42;
        awvalid = 1; awready = 1; awaddr = 40'h90000008; awlen = 0;
        wvalid  = 1; wready  = 1; wdata  = d; wstrb = 16'h000F;
        tick();
        awvalid = 0; awready = 0; wvalid = 0; wready = 0;
        tests++; if (con_data !== 8'h42 || con_vld !== 1'b1) begin fails++; $display("FAIL con_same_cycle got=%0h/%0d exp=42/1", con_data, con_vld); end
        con_rdy = 1'b1;
        tick();
        con_rdy = 1'b0;
        w_beat(d, 16'h000F);
        tests++; if (con_vld !== 1'b0) begin fails++; $display("FAIL con_no_pending got=%0d exp=0", con_vld); end
    endtask

    task automatic test_overflow();
        logic [127:0] d;
        logic [7:0]   exp_b;
        do_reset();
        mon_en = 1'b0;
        for (int i = 0; i < 17; i++) begin
            d = '0;
            d[32*(i%4) +: 8] = 8'(8'h60 + i);
            aw_beat(CON_A, 8'd0);
            w_beat(d, 16'h000F << (4 * (i % 4)));
        end
        tests++; if (con_vld !== 1'b1)   begin fails++; $display("FAIL ovf_vld got=%0d exp=1", con_vld); end
        tests++; if (con_ovf !== 1'b1)   begin fails++; $display("FAIL ovf_flag got=%0d exp=1", con_ovf); end
        tests++; if (con_data !== 8'h60) begin fails++; $display("FAIL ovf_head got=%0h exp=60", con_data); end
        aw_beat(CON_A, 8'd0);
        d = '0;
        d[39:32] = 8'h80;
        con_rdy = 1'b1;
        w_beat(d, 16'h00F0);
        con_rdy = 1'b0;
        tests++; if (con_data !== 8'h61) begin fails++; $display("FAIL full_pushpop_head got=%0h exp=61", con_data); end
        con_rdy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_b = (i < 15) ? 8'(8'h61 + i) : 8'h80;
            tests++; if (con_vld !== 1'b1 || con_data !== exp_b) begin fails++; $display("FAIL drain_%0d got=%0h/%0d exp=%0h/1", i, con_data, con_vld, exp_b); end
            tick();
        end
        con_rdy = 1'b0;
        tests++; if (con_vld !== 1'b0) begin fails++; $display("FAIL drain_empty got=%0d exp=0", con_vld); end
        tests++; if (con_ovf !== 1'b1) begin fails++; $display("FAIL ovf_sticky got=%0d exp=1", con_ovf); end
    endtask

    task automatic test_reset_mid();
        logic [127:0] d;
        do_reset();
        mon_en = 1'b0;
        retire = 2'b11;
        for (int i = 0; i < 5; i++) begin
            d = '0;
            d[7:0] = 8'(8'h30 + i);
            aw_beat(CON_A, 8'd0);
            w_beat(d, 16'h000F);
        end
        retire = 2'b00;
        aw_beat(CON_A, 8'd0);
        tests++; if (con_data !== 8'h30 || instret === 64'd0) begin fails++; $display("FAIL mid_setup got=%0h/%0d exp=30/nonzero", con_data, instret); end
        #2;
        rst_b = 1'b0;
        model_reset();
        #1;
        tests++; if (con_vld !== 1'b0)   begin fails++; $display("FAIL mid_con_vld got=%0d exp=0", con_vld); end
        tests++; if (con_data !== 8'h0)  begin fails++; $display("FAIL mid_con_data got=%0h exp=0", con_data); end
        tests++; if (cycles !== 64'd0)   begin fails++; $display("FAIL mid_cycles got=%0d exp=0", cycles); end
        tests++; if (instret !== 64'd0)  begin fails++; $display("FAIL mid_instret got=%0d exp=0", instret); end
        tests++; if (status !== 2'd0)    begin fails++; $display("FAIL mid_status got=%0d exp=0", status); end
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        d = '0;
        d[7:0] = 8'h55;
        w_beat(d, 16'h000F);
        tests++; if (con_vld !== 1'b0) begin fails++; $display("FAIL mid_pending_cleared got=%0d exp=0", con_vld); end
    endtask

    task automatic test_random();
        do_reset();
        for (int it = 0; it < 2000; it++) begin
            if ($urandom_range(0, 119) == 0) do_reset();
            mon_en  = ($urandom_range(0, 15) != 0);
            retire  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            wb_vld  = ($urandom_range(0, 47) == 0) ? 2'($urandom) : 2'b00;
            for (int k = 0; k < 2; k++) begin
                case ($urandom_range(0, 2))
                    0:       wb_data[k*64 +: 64] = PASS_V;
                    1:       wb_data[k*64 +: 64] = FAIL_V;
                    default: wb_data[k*64 +: 64] = {$urandom, $urandom};
                endcase
            end
            awvalid = ($urandom_range(0, 3) == 0);
            awready = ($urandom_range(0, 3) != 0);
            awaddr  = ($urandom_range(0, 3) != 0) ? CON_A + 40'($urandom_range(0, 31)) : {8'($urandom), $urandom};
            awlen   = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
            wvalid  = ($urandom_range(0, 2) == 0);
            wready  = ($urandom_range(0, 3) != 0);
            wdata   = {$urandom, $urandom, $urandom, $urandom};
            wstrb   = ($urandom_range(0, 3) != 0) ? (16'h000F << (4 * $urandom_range(0, 3))) : 16'($urandom);
            con_rdy = ((it / 64) % 2 == 0) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 1) == 1);
            tick();
            tests++; if (status !== m_status) begin fails++; $display("FAIL rnd_status it=%0d got=%0d exp=%0d", it, status, m_status); end
            tests++; if (done !== (m_status != 2'd0)) begin fails++; $display("FAIL rnd_done it=%0d got=%0d exp=%0d", it, done, m_status != 2'd0); end
            tests++; if (cycles !== m_cycles) begin fails++; $display("FAIL rnd_cycles it=%0d got=%0d exp=%0d", it, cycles, m_cycles); end
            tests++; if (instret !== m_instret) begin fails++; $display("FAIL rnd_instret it=%0d got=%0d exp=%0d", it, instret, m_instret); end
            tests++; if (con_vld !== (q.size() != 0)) begin fails++; $display("FAIL rnd_con_vld it=%0d got=%0d exp=%0d", it, con_vld, q.size() != 0); end
            tests++; if (con_ovf !== m_ovf) begin fails++; $display("FAIL rnd_con_ovf it=%0d got=%0d exp=%0d", it, con_ovf, m_ovf); end
            if (q.size() != 0) begin
                tests++; if (con_data !== q[0]) begin fails++; $display("FAIL rnd_con_data it=%0d got=%0h exp=%0h", it, con_data, q[0]); end
            end
        end
        idle_inputs();
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        idle_inputs();
        rst_b = 1'b0;
        test_reset();
        test_pass();
        test_priority();
        test_watchdog();
        test_console();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
